// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg_2w(input logic [W2-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic               is_div_q, sign_a_q, sign_b_q, dz_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, dbz_q, dbz_d;

  logic               accept, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;
  logic [W2-1:0]      mul_step, div_step, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res_hi, res_lo;

  assign accept   = (state_q == S_IDLE) && start;
  assign a_neg    = ~op[0] & operand_a[WIDTH-1];
  assign b_neg    = ~op[0] & operand_b[WIDTH-1];
  assign b_zero   = (operand_b == '0);
  // 0x80000000 negates to itself, which is exactly its 2^31 magnitude.
  assign mag_a_in = cond_neg_w(operand_a, a_neg);
  assign mag_b_in = cond_neg_w(operand_b, b_neg);

  // Shift-add: work_q = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, mag_a_q} : '0);
  assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring division: work_q = {partial remainder, dividend/quotient bits}.
  assign rem_sh   = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, mag_b_q};
  assign div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  assign prod_s = cond_neg_2w(work_q, sign_a_q ^ sign_b_q);
  assign quo_s  = cond_neg_w(work_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
  assign rem_s  = cond_neg_w(work_q[W2-1:WIDTH], sign_a_q);

  always_comb begin
    res_hi = prod_s[W2-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (dz_q) begin
      res_hi = work_q[W2-1:WIDTH];
      res_lo = work_q[WIDTH-1:0];
    end else if (is_div_q) begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[1] && b_zero)
            state_d = S_FINISH;
`ifdef MULDIV_FAST_MUL_EN
          else if (!op[1])
            state_d = S_FINISH;
`endif
          else
            state_d = S_RUN;
        end
      end
      S_RUN:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    if (accept) begin
      cnt_d = '0;
      if (op[1] && b_zero)
        work_d = {operand_a, {WIDTH{1'b1}}};
      else if (op[1])
        work_d = {{WIDTH{1'b0}}, mag_a_in};
      else
`ifdef MULDIV_FAST_MUL_EN
        work_d = {{WIDTH{1'b0}}, mag_a_in} * {{WIDTH{1'b0}}, mag_b_in};
`else
        work_d = {{WIDTH{1'b0}}, mag_b_in};
`endif
    end else if (state_q == S_RUN) begin
      cnt_d  = cnt_q + 1'b1;
      work_d = is_div_q ? div_step : mul_step;
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    dbz_d = dbz_q;
    if (state_q == S_FINISH) begin
      hi_d = res_hi;
      lo_d = res_lo;
      if (dz_q) dbz_d = 1'b1;
    end else if (accept) begin
      dbz_d = 1'b0;
    end else if ((state_q == S_IDLE) && hilo_we) begin
      if (hilo_sel) hi_d = hilo_wdata;
      else          lo_d = hilo_wdata;
    end
  end

  // Operand/working registers: only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    cnt_q  <= cnt_d;
    if (accept) begin
      is_div_q <= op[1];
      sign_a_q <= a_neg;
      sign_b_q <= b_neg;
      dz_q     <= op[1] && b_zero;
      mag_a_q  <= mag_a_in;
      mag_b_q  <= mag_b_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_d == S_FINISH);
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed vectors.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0, operand_b = '0, hilo_wdata = '0;
  logic        hilo_we = 1'b0, hilo_sel = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic signed [63:0] sa, sb, r, q;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    h = '0; l = '0; dz = 1'b0;
    case (o)
      2'd0: begin r = sa * sb; h = r[63:32]; l = r[31:0]; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; h = u[63:32]; l = u[31:0]; end
      default: begin
        if (b == 0) begin
          dz = 1'b1; h = a; l = 32'hFFFFFFFF;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  logic        m_busy = 1'b0, m_dbz = 1'b0, p_dz = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_cnt = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_hi = p_hi; m_lo = p_lo;
        if (p_dz) m_dbz = 1'b1;
      end
    end else if (start) begin
      model_op(op, operand_a, operand_b, p_hi, p_lo, p_dz);
      m_busy = 1'b1;
      m_dbz  = 1'b0;
      m_cnt  = p_dz ? 1 : (!op[1] ? MUL_LAT : 33);
    end else if (hilo_we) begin
      if (hilo_sel) m_hi = hilo_wdata;
      else          m_lo = hilo_wdata;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_busy && (m_cnt == 1));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", div_by_zero, m_dbz);
    end
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat, n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_dbz", div_by_zero, 0);

    run_op(2'd0, 32'hFFFFFFFF, 32'h2, lat);
    chk("mult_lat", lat, MUL_LAT); chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFE);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_hi", hi, 32'hFFFFFFFE); chk("multu_lo", lo, 32'h1);

    run_op(2'd2, 32'hFFFFFFF9, 32'h2, lat);
    chk("div_lat", lat, 33); chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);

    run_op(2'd3, 32'd7, 32'd2, lat);
    chk("divu_hi", hi, 1); chk("divu_lo", lo, 3);

    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("divovf_hi", hi, 0); chk("divovf_lo", lo, 32'h80000000);

    run_op(2'd3, 32'd5, 32'd0, lat);
    chk("dz_lat", lat, 1); chk("dz_hi", hi, 5); chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_flag", div_by_zero, 1);

    run_op(2'd1, 32'd3, 32'd4, lat);
    chk("dzclr_flag", div_by_zero, 0); chk("dzclr_hi", hi, 0); chk("dzclr_lo", lo, 12);

    // Start and MTHI while busy are both ignored; MTHI also held across FINISH.
    @(negedge clk);
    op = 2'd3; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 10) begin
        start = 1'b1; op = 2'd3; operand_a = 32'd9; operand_b = 32'd2;
      end else begin
        start = 1'b0;
      end
      if (n == 20) begin
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
      end
      @(negedge clk);
      n++;
    end
    chk("conf_lat", n, 33);
    @(negedge clk);
    hilo_we = 1'b0;
    chk("conf_hi", hi, 2); chk("conf_lo", lo, 14);

    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("mthi_hi", hi, 32'h1234); chk("mthi_lo", lo, 14);

    @(negedge clk);
    op = 2'd1; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    wait_done(lat);
    chk("startwins_hi", hi, 0); chk("startwins_lo", lo, 6);

    @(negedge clk);
    op = 2'd2; operand_a = 32'hFFFFFF9C; operand_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0); chk("midrst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'd6, 32'd7, lat);
    chk("post_hi", hi, 0); chk("post_lo", lo, 42);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
